// File: rtl/interp_pkg.sv
// Constants and bank-state encoding shared by the window loader, the
// sub-pixel interpolator and their benches.
package interp_pkg;

    localparam int N     = 15;
    localparam int PW    = 8;
    localparam int BUF_W = N * N * PW;

    localparam logic [7:0] LAST_IDX = 8'(N * N - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        PRESENTED
    } bank_state_e;

endpackage

// File: rtl/win_bank.sv
// One window bank: a flat pixel register with an indexed pixel write and a
// valid flag marking that the register holds a complete window.
module win_bank
    import interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_idx,
    input  logic [PW-1:0]    wr_data,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic [BUF_W-1:0] data,
    output logic             valid
);

    logic [10:0] bit_lo;

    assign bit_lo = {wr_idx, 3'b000};

    // Pixel storage carries no reset; readers qualify it with valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[bit_lo +: PW] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (clr_valid) begin
            valid <= 1'b0;
        end else if (set_valid) begin
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ref_window_loader.sv
// Assembles raster-order reference pixels into N x N windows across two
// ping-pong banks and presents completed windows to the interpolator.
module ref_window_loader
    import interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    pix_in,
    input  logic             pix_sof,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [BUF_W-1:0] win_buf,
    output logic             win_valid,
    input  logic             win_ack,
    output logic             err_sof
);

    bank_state_e      st_q [2];
    bank_state_e      st_d [2];
    logic             fill_ptr, fill_ptr_d;
    logic             pres_ptr, pres_ptr_d;
    logic [7:0]       idx, idx_d;
    logic [7:0]       wr_idx;
    logic             accept, ack, sof_miss, sof_early, store, last;
    logic             ready_d, valid_d, err_d;
    logic [BUF_W-1:0] bank_data [2];
    logic [1:0]       bank_vld;

    always_comb begin
        st_d       = st_q;
        fill_ptr_d = fill_ptr;
        pres_ptr_d = pres_ptr;
        idx_d      = idx;

        accept    = pix_valid && pix_ready;
        ack       = win_valid && win_ack;
        sof_miss  = accept && (idx == 8'd0) && !pix_sof;
        sof_early = accept && (idx != 8'd0) && pix_sof;
        store     = accept && !sof_miss;
        wr_idx    = sof_early ? 8'd0 : idx;
        last      = store && (wr_idx == LAST_IDX);

        // Release the presented bank before promotion so a completing bank
        // can take over on the same edge without a bubble.
        if (ack) begin
            st_d[pres_ptr] = EMPTY;
        end
        if (store) begin
            if (last) begin
                st_d[fill_ptr] = FULL;
                fill_ptr_d     = ~fill_ptr;
                idx_d          = 8'd0;
            end else begin
                st_d[fill_ptr] = FILLING;
                idx_d          = wr_idx + 8'd1;
            end
        end
        if (st_d[0] != PRESENTED && st_d[1] != PRESENTED) begin
            if (st_d[0] == FULL) begin
                st_d[0]    = PRESENTED;
                pres_ptr_d = 1'b0;
            end else if (st_d[1] == FULL) begin
                st_d[1]    = PRESENTED;
                pres_ptr_d = 1'b1;
            end
        end

        valid_d = (st_d[0] == PRESENTED) || (st_d[1] == PRESENTED);
        ready_d = (st_d[fill_ptr_d] == EMPTY) || (st_d[fill_ptr_d] == FILLING);
        err_d   = sof_miss || sof_early;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            fill_ptr  <= 1'b0;
            pres_ptr  <= 1'b0;
            idx       <= 8'd0;
            pix_ready <= 1'b0;
            win_valid <= 1'b0;
            err_sof   <= 1'b0;
        end else begin
            st_q      <= st_d;
            fill_ptr  <= fill_ptr_d;
            pres_ptr  <= pres_ptr_d;
            idx       <= idx_d;
            pix_ready <= ready_d;
            win_valid <= valid_d;
            err_sof   <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        win_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (store && (fill_ptr == 1'(b))),
            .wr_idx    (wr_idx),
            .wr_data   (pix_in),
            .set_valid (last && (fill_ptr == 1'(b))),
            .clr_valid (ack && (pres_ptr == 1'(b))),
            .data      (bank_data[b]),
            .valid     (bank_vld[b])
        );
    end

    // Gating on win_valid makes the output read zero during and after reset.
    assign win_buf = (win_valid && bank_vld[pres_ptr]) ? bank_data[pres_ptr] : '0;

endmodule

// File: tb/tb_ref_window_loader.sv
// Directed bench for ref_window_loader: a queue-of-windows reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_ref_window_loader;
    import interp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [PW-1:0]    pix_in;
    logic             pix_sof;
    logic             pix_valid;
    logic             pix_ready;
    logic [BUF_W-1:0] win_buf;
    logic             win_valid;
    logic             win_ack;
    logic             err_sof;

    int checks = 0;
    int errors = 0;

    ref_window_loader dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_buf   (win_buf),
        .win_valid (win_valid),
        .win_ack   (win_ack),
        .err_sof   (err_sof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [BUF_W-1:0] v, input int i);
        logic [10:0] lo;
        lo = 11'(i * 8);
        return v[lo +: 8];
    endfunction

    // Model: completed windows queue in arrival order; the head is presented.
    logic [BUF_W-1:0] m_q[$];
    logic [BUF_W-1:0] m_cur;
    logic [7:0]       m_idx;
    logic             m_ready, m_valid, m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_cur   = '0;
            m_idx   = 8'd0;
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            logic acc;
            logic [10:0] lo;
            acc   = pix_valid && m_ready;
            m_err = 1'b0;
            if (m_valid && win_ack) void'(m_q.pop_front());
            if (acc) begin
                if (m_idx == 8'd0 && !pix_sof) begin
                    m_err = 1'b1;
                end else begin
                    if (m_idx != 8'd0 && pix_sof) begin
                        m_err = 1'b1;
                        m_idx = 8'd0;
                    end
                    lo = 11'(int'(m_idx) * 8);
                    m_cur[lo +: 8] = pix_in;
                    if (m_idx == 8'd224) begin
                        m_q.push_back(m_cur);
                        m_idx = 8'd0;
                    end else begin
                        m_idx = m_idx + 8'd1;
                    end
                end
            end
            m_valid = (m_q.size() > 0);
            m_ready = (m_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        logic [BUF_W-1:0] exp_buf;
        int bad;
        exp_buf = (m_valid && m_q.size() > 0) ? m_q[0] : '0;
        chk("pix_ready", 32'(pix_ready), 32'(m_ready));
        chk("win_valid", 32'(win_valid), 32'(m_valid));
        chk("err_sof", 32'(err_sof), 32'(m_err));
        checks++;
        if (win_buf !== exp_buf) begin
            errors++;
            bad = -1;
            for (int i = 0; i < N * N; i++) begin
                if (bad < 0 && get_byte(win_buf, i) !== get_byte(exp_buf, i)) bad = i;
            end
            $display("FAIL win_buf: byte %0d got 0x%0h, expected 0x%0h", bad,
                     get_byte(win_buf, bad < 0 ? 0 : bad), get_byte(exp_buf, bad < 0 ? 0 : bad));
        end
    end

    function automatic logic [7:0] pix_of(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'hAA;
            default: return 8'(i * 7 + kind * 31);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic a);
        int waited;
        waited    = 0;
        pix_in    = d;
        pix_sof   = s;
        pix_valid = 1'b1;
        while (!pix_ready && waited < 2000) begin
            tick();
            waited++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: pix_ready stuck at 0 after %0d cycles, expected 1", waited);
        end
        win_ack = a;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        win_ack   = 1'b0;
    endtask

    task automatic send_win(input int kind, input logic ack_last);
        for (int i = 0; i < N * N; i++) begin
            beat(pix_of(kind, i), i == 0, ack_last && (i == N * N - 1));
        end
    endtask

    task automatic do_ack();
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        pix_in    = '0;
        pix_sof   = 1'b0;
        pix_valid = 1'b0;
        win_ack   = 1'b0;
        repeat (3) tick();
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_err_sof", 32'(err_sof), 32'd0);
        chk("rst_win_buf_nonzero", 32'(win_buf != '0), 32'd0);
        rst = 1'b1;
        tick();
        chk("ready_after_release", 32'(pix_ready), 32'd1);

        // Window 1: pixel (r,c) = r*15+c
        for (int i = 0; i < N * N - 1; i++) beat(pix_of(0, i), i == 0, 1'b0);
        chk("w1_valid_before_last", 32'(win_valid), 32'd0);
        beat(pix_of(0, N * N - 1), 1'b0, 1'b0);
        chk("w1_valid_after_last", 32'(win_valid), 32'd1);
        chk("w1_byte0", 32'(get_byte(win_buf, 0)), 32'h00);
        chk("w1_byte1", 32'(get_byte(win_buf, 1)), 32'h01);
        chk("w1_byte15", 32'(get_byte(win_buf, 15)), 32'h0F);
        chk("w1_byte224", 32'(get_byte(win_buf, 224)), 32'hE0);

        // Window 2 fills the other bank while window 1 is held
        send_win(1, 1'b0);
        chk("w2_backpressure", 32'(pix_ready), 32'd0);
        repeat (3) tick();
        chk("w2_hold_valid", 32'(win_valid), 32'd1);
        chk("w2_hold_byte224", 32'(get_byte(win_buf, 224)), 32'hE0);
        do_ack();
        chk("w2_swap_valid", 32'(win_valid), 32'd1);
        chk("w2_swap_byte0", 32'(get_byte(win_buf, 0)), 32'hAA);
        chk("w2_swap_byte224", 32'(get_byte(win_buf, 224)), 32'hAA);
        chk("w2_swap_ready", 32'(pix_ready), 32'd1);
        do_ack();
        chk("w2_drain_valid", 32'(win_valid), 32'd0);

        // Missing sof on the first beat
        beat(8'h55, 1'b0, 1'b0);
        chk("miss_sof_pulse", 32'(err_sof), 32'd1);
        tick();
        chk("miss_sof_single", 32'(err_sof), 32'd0);
        send_win(2, 1'b0);
        chk("miss_sof_valid", 32'(win_valid), 32'd1);
        chk("miss_sof_byte0", 32'(get_byte(win_buf, 0)), 32'h3E);
        do_ack();

        // Early sof at beat 100 restarts the window
        for (int i = 0; i < 100; i++) beat(pix_of(3, i), i == 0, 1'b0);
        beat(8'h9C, 1'b1, 1'b0);
        chk("early_sof_pulse", 32'(err_sof), 32'd1);
        for (int j = 1; j < N * N - 1; j++) beat(pix_of(3, j), 1'b0, 1'b0);
        chk("early_sof_not_done", 32'(win_valid), 32'd0);
        beat(pix_of(3, N * N - 1), 1'b0, 1'b0);
        chk("early_sof_done", 32'(win_valid), 32'd1);
        chk("early_sof_byte0", 32'(get_byte(win_buf, 0)), 32'h9C);
        do_ack();

        // Ack coincident with the last beat of the next window
        send_win(4, 1'b0);
        send_win(5, 1'b1);
        chk("coinc_valid", 32'(win_valid), 32'd1);
        chk("coinc_byte0", 32'(get_byte(win_buf, 0)), 32'(pix_of(5, 0)));
        chk("coinc_byte224", 32'(get_byte(win_buf, 224)), 32'(pix_of(5, 224)));
        chk("coinc_ready", 32'(pix_ready), 32'd1);
        do_ack();
        chk("coinc_drain", 32'(win_valid), 32'd0);

        // Reset mid-fill while a window is presented
        send_win(6, 1'b0);
        for (int i = 0; i < 50; i++) beat(pix_of(7, i), i == 0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(win_valid), 32'd0);
        chk("async_rst_buf_nonzero", 32'(win_buf != '0), 32'd0);
        chk("async_rst_ready", 32'(pix_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(pix_ready), 32'd1);
        send_win(8, 1'b0);
        chk("post_rst_valid", 32'(win_valid), 32'd1);
        chk("post_rst_byte0", 32'(get_byte(win_buf, 0)), 32'(pix_of(8, 0)));
        chk("post_rst_byte50", 32'(get_byte(win_buf, 50)), 32'(pix_of(8, 50)));
        do_ack();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
